// File: rtl/piece_motion_ctrl_pkg.sv
// Shared definitions for the falling-piece mover: FSM state encoding,
// move directions and playfield index helpers.
package piece_motion_ctrl_pkg;

    localparam int DEF_COLS = 12;
    localparam int DEF_ROWS = 12;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_LOCKING   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_e;

    function automatic int idx_row(input int idx, input int cols);
        return idx / cols;
    endfunction

    function automatic int idx_col(input int idx, input int cols);
        return idx % cols;
    endfunction

endpackage

// File: rtl/piece_motion_ctrl_grid_move_check.sv
// Combinational one-step shift of a piece bitmap in one direction, flagging a
// collision with the playfield edge or with the settled background.
module grid_move_check
    import piece_motion_ctrl_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    localparam int N   = COLS * ROWS
) (
    input  logic [N-1:0] piece,
    input  logic [N-1:0] background,
    input  logic [1:0]   dir,
    output logic         blocked,
    output logic [N-1:0] shifted
);

    logic edge_hit;

    always_comb begin
        edge_hit = 1'b0;
        shifted  = '0;
        // Squares that would wrap across a row are caught as edge hits, so the
        // wrapped bits in shifted never get applied.
        case (dir)
            DIR_DOWN: shifted = piece << COLS;
            DIR_LEFT: shifted = piece >> 1;
            default:  shifted = piece << 1;
        endcase
        for (int i = 0; i < N; i++) begin
            if (piece[i]) begin
                case (dir)
                    DIR_DOWN: if (idx_row(i, COLS) == ROWS - 1) edge_hit = 1'b1;
                    DIR_LEFT: if (idx_col(i, COLS) == 0)        edge_hit = 1'b1;
                    default:  if (idx_col(i, COLS) == COLS - 1) edge_hit = 1'b1;
                endcase
            end
        end
        blocked = edge_hit | (|(shifted & background));
    end

endmodule

// File: rtl/piece_motion_ctrl.sv
// Falling-piece controller: spawn acceptance, gravity/soft-drop/left/right moves
// with collision checks, lock delay and hand-off of the locked piece.
module piece_motion_ctrl
    import piece_motion_ctrl_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int LOCK_DELAY = 2,
    localparam int N         = COLS * ROWS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] background,
    input  logic         spawn_valid,
    input  logic [N-1:0] spawn_sqs,
    output logic         spawn_ready,
    input  logic         gravity_tick,
    input  logic         move_down,
    input  logic         move_left,
    input  logic         move_right,
    output logic [N-1:0] current_sqs,
    output logic         move_blocked,
    output logic         lock_valid,
    output logic [N-1:0] lock_sqs,
    output logic         game_over
);

    localparam int CW = (LOCK_DELAY > 0) ? $clog2(LOCK_DELAY + 1) : 1;

    state_e        state_q;
    logic [N-1:0]  cur_q;
    logic [N-1:0]  lock_sqs_q;
    logic [CW-1:0] lock_cnt_q;
    logic          blocked_q;
    logic          lock_valid_q;
    logic          game_over_q;

    logic          dn_blk, lf_blk, rt_blk;
    logic [N-1:0]  dn_sh, lf_sh, rt_sh;
    logic          dn_req, lf_req, rt_req;
    logic          lock_now;

    grid_move_check #(.COLS(COLS), .ROWS(ROWS)) u_chk_down (
        .piece(cur_q), .background(background), .dir(DIR_DOWN),
        .blocked(dn_blk), .shifted(dn_sh)
    );
    grid_move_check #(.COLS(COLS), .ROWS(ROWS)) u_chk_left (
        .piece(cur_q), .background(background), .dir(DIR_LEFT),
        .blocked(lf_blk), .shifted(lf_sh)
    );
    grid_move_check #(.COLS(COLS), .ROWS(ROWS)) u_chk_right (
        .piece(cur_q), .background(background), .dir(DIR_RIGHT),
        .blocked(rt_blk), .shifted(rt_sh)
    );

    // One request granted per cycle: down beats left beats right.
    assign dn_req = gravity_tick | move_down;
    assign lf_req = move_left & ~dn_req;
    assign rt_req = move_right & ~dn_req & ~move_left;

    // A blocked down from ACTIVE is the first strike; from LOCKING it adds one.
    assign lock_now = (state_q == ST_ACTIVE) ? (LOCK_DELAY == 0)
                                             : ((int'(lock_cnt_q) + 1) >= LOCK_DELAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            lock_sqs_q   <= '0;
            lock_cnt_q   <= '0;
            blocked_q    <= 1'b0;
            lock_valid_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            blocked_q    <= 1'b0;
            lock_valid_q <= 1'b0;
            lock_sqs_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (spawn_valid) begin
                        if (|(spawn_sqs & background)) begin
                            state_q     <= ST_GAME_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            cur_q   <= spawn_sqs;
                            state_q <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE, ST_LOCKING: begin
                    if (dn_req) begin
                        if (!dn_blk) begin
                            cur_q      <= dn_sh;
                            lock_cnt_q <= '0;
                            state_q    <= ST_ACTIVE;
                        end else if (lock_now) begin
                            lock_valid_q <= 1'b1;
                            lock_sqs_q   <= cur_q;
                            cur_q        <= '0;
                            lock_cnt_q   <= '0;
                            state_q      <= ST_IDLE;
                        end else begin
                            blocked_q  <= 1'b1;
                            lock_cnt_q <= (state_q == ST_ACTIVE) ? '0 : lock_cnt_q + 1'b1;
                            state_q    <= ST_LOCKING;
                        end
                    end else if (lf_req) begin
                        if (lf_blk) blocked_q <= 1'b1;
                        else        cur_q     <= lf_sh;
                    end else if (rt_req) begin
                        if (rt_blk) blocked_q <= 1'b1;
                        else        cur_q     <= rt_sh;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spawn_ready  = (state_q == ST_IDLE);
    assign current_sqs  = cur_q;
    assign move_blocked = blocked_q;
    assign lock_valid   = lock_valid_q;
    assign lock_sqs     = lock_sqs_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Scoreboard bench for piece_motion_ctrl: directed scenarios plus random play,
// checked against a coordinate-level model of the playfield rules.
module tb_piece_motion_ctrl;

    localparam int C  = 12;
    localparam int R  = 12;
    localparam int LD = 2;
    localparam int N  = C * R;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] background = '0;
    logic         spawn_valid = 1'b0;
    logic [N-1:0] spawn_sqs = '0;
    logic         spawn_ready;
    logic         gravity_tick = 1'b0;
    logic         move_down = 1'b0;
    logic         move_left = 1'b0;
    logic         move_right = 1'b0;
    logic [N-1:0] current_sqs;
    logic         move_blocked;
    logic         lock_valid;
    logic [N-1:0] lock_sqs;
    logic         game_over;

    piece_motion_ctrl #(.COLS(C), .ROWS(R), .LOCK_DELAY(LD)) dut (
        .clk(clk), .rst_n(rst_n), .background(background),
        .spawn_valid(spawn_valid), .spawn_sqs(spawn_sqs), .spawn_ready(spawn_ready),
        .gravity_tick(gravity_tick), .move_down(move_down),
        .move_left(move_left), .move_right(move_right),
        .current_sqs(current_sqs), .move_blocked(move_blocked),
        .lock_valid(lock_valid), .lock_sqs(lock_sqs), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] cur;
        logic [N-1:0] lsq;
        logic         blk;
        logic         lv;
        logic         go;
        logic         rdy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    // Model of the rules: which squares the piece covers, whether a piece is in
    // play, how many blocked downs it has absorbed, and whether the game ended.
    logic [N-1:0] m_cur;
    logic         m_has;
    logic         m_over;
    int           m_bdowns;
    logic [N-1:0] bg_v;
    logic         last_lv;
    logic [N-1:0] last_lsq;

    function automatic logic [N-1:0] sq(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic try_move(input logic [N-1:0] p, input logic [N-1:0] b,
                            input int dr, input int dc,
                            output logic blk, output logic [N-1:0] np);
        int nr, nc;
        blk = 1'b0;
        np  = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (p[r*C+c]) begin
                    nr = r + dr;
                    nc = c + dc;
                    if (nr < 0 || nr >= R || nc < 0 || nc >= C) blk = 1'b1;
                    else begin
                        if (b[nr*C+nc]) blk = 1'b1;
                        np[nr*C+nc] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask

    task automatic model_reset();
        m_cur = '0; m_has = 1'b0; m_over = 1'b0; m_bdowns = 0;
        last_lv = 1'b0; last_lsq = '0;
    endtask

    task automatic step(input string nm, input logic g, input logic md, input logic ml,
                        input logic mr, input logic sv, input logic [N-1:0] ss);
        exp_t e;
        logic down, left, right, b;
        logic [N-1:0] np;
        @(negedge clk);
        background = bg_v; gravity_tick = g; move_down = md;
        move_left = ml; move_right = mr; spawn_valid = sv; spawn_sqs = ss;
        e = '0;
        down  = g | md;
        left  = ml & ~down;
        right = mr & ~down & ~ml;
        if (m_over) begin
        end else if (!m_has) begin
            if (sv) begin
                if ((ss & bg_v) != '0) m_over = 1'b1;
                else begin m_cur = ss; m_has = 1'b1; m_bdowns = 0; end
            end
        end else if (down) begin
            try_move(m_cur, bg_v, 1, 0, b, np);
            if (!b) begin m_cur = np; m_bdowns = 0; end
            else begin
                m_bdowns++;
                if (m_bdowns > LD) begin
                    e.lv = 1'b1; e.lsq = m_cur; m_cur = '0; m_has = 1'b0;
                end else e.blk = 1'b1;
            end
        end else if (left || right) begin
            try_move(m_cur, bg_v, 0, left ? -1 : 1, b, np);
            if (b) e.blk = 1'b1;
            else   m_cur = np;
        end
        e.cur = m_cur;
        e.go  = m_over;
        e.rdy = !m_has && !m_over;
        last_lv = e.lv; last_lsq = e.lsq;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input string nm);
        step(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        gravity_tick = 0; move_down = 0; move_left = 0; move_right = 0;
        spawn_valid = 0; spawn_sqs = '0;
        rst_n = 1'b0;
        exp_q.delete(); name_q.delete();
        model_reset();
        #1;
        chk({nm, "_rst_cur"}, current_sqs, '0);
        chk({nm, "_rst_lsq"}, lock_sqs, '0);
        chk({nm, "_rst_flags"}, {move_blocked, lock_valid, game_over}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({nm, "_rst_ready"}, spawn_ready, 1);
    endtask

    // Monitor: one expected record per cycle, compared just after the edge.
    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (current_sqs === e.cur && lock_sqs === e.lsq && move_blocked === e.blk &&
                    lock_valid === e.lv && game_over === e.go && spawn_ready === e.rdy)
                    n_pass++;
                else
                    $display("FAIL %s: got cur=%h lsq=%h blk=%b lv=%b go=%b rdy=%b expected cur=%h lsq=%h blk=%b lv=%b go=%b rdy=%b",
                             nm, current_sqs, lock_sqs, move_blocked, lock_valid, game_over,
                             spawn_ready, e.cur, e.lsq, e.blk, e.lv, e.go, e.rdy);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N-1:0] p;
        int r, c;
        bg_v = '0;
        model_reset();

        // Gravity to the floor, lock delay, lock hand-off.
        do_reset("t1");
        step("t1_spawn", 0, 0, 0, 0, 1, sq(5));
        for (int i = 0; i < 11; i++) step("t1_fall", 1, 0, 0, 0, 0, '0);
        settle();
        chk("t1_floor", current_sqs, sq(137));
        step("t1_blk", 1, 0, 0, 0, 0, '0);
        step("t1_strike2", 1, 0, 0, 0, 0, '0);
        step("t1_lock", 1, 0, 0, 0, 0, '0);
        settle();
        chk("t1_lock_sqs", lock_sqs, sq(137));
        chk("t1_lock_flags", {lock_valid, spawn_ready, current_sqs}, {2'b11, {N{1'b0}}});
        idle("t1_after");

        // Walls, including no wrap between rows.
        do_reset("t2");
        step("t2_spawn12", 0, 0, 0, 0, 1, sq(12));
        step("t2_left", 0, 0, 1, 0, 0, '0);
        settle();
        chk("t2_left_wall", {move_blocked, current_sqs}, {1'b1, sq(12)});
        do_reset("t2b");
        step("t2_spawn11", 0, 0, 0, 0, 1, sq(11));
        step("t2_right", 0, 0, 0, 1, 0, '0);
        settle();
        chk("t2_right_wall", {move_blocked, current_sqs}, {1'b1, sq(11)});

        // Background collision, slide away, fall again.
        do_reset("t3");
        bg_v = sq(17);
        step("t3_spawn", 0, 0, 0, 0, 1, sq(5));
        step("t3_grav_blk", 1, 0, 0, 0, 0, '0);
        step("t3_left", 0, 0, 1, 0, 0, '0);
        step("t3_grav", 1, 0, 0, 0, 0, '0);
        settle();
        chk("t3_pos16", current_sqs, sq(16));
        step("t3_grav2", 0, 1, 0, 0, 0, '0);
        bg_v = '0;

        // Down wins over left in the same cycle.
        do_reset("t4");
        step("t4_spawn", 0, 0, 0, 0, 1, sq(5));
        step("t4_both", 1, 0, 1, 0, 0, '0);
        settle();
        chk("t4_down_wins", {move_blocked, current_sqs}, {1'b0, sq(17)});
        step("t4_lr", 0, 0, 1, 1, 0, '0);

        // Spawn collision ends the game.
        do_reset("t5");
        bg_v = sq(5);
        step("t5_spawn", 0, 0, 0, 0, 1, sq(5));
        settle();
        chk("t5_over", {game_over, spawn_ready, current_sqs}, {2'b10, {N{1'b0}}});
        bg_v = '0;
        step("t5_spawn_again", 0, 0, 0, 0, 1, sq(40));
        step("t5_moves", 1, 1, 1, 1, 1, sq(41));

        // Reset while locking drops the piece with no lock pulse.
        do_reset("t6");
        step("t6_spawn", 0, 0, 0, 0, 1, sq(135));
        step("t6_grav_blk", 1, 0, 0, 0, 0, '0);
        do_reset("t6_mid");
        idle("t6_idle1");
        idle("t6_idle2");

        // Random play; locked pieces are merged into the background.
        for (int game = 0; game < 4; game++) begin
            do_reset("rnd");
            bg_v = '0;
            for (int i = 4 * C; i < N; i++) bg_v[i] = ($urandom_range(0, 5) == 0);
            for (int cyc = 0; cyc < 300; cyc++) begin
                p = '0;
                r = $urandom_range(0, 3);
                c = $urandom_range(0, C - 2);
                p[r*C+c] = 1'b1;
                if ($urandom_range(0, 1) == 1) p[r*C+c+1] = 1'b1;
                if ($urandom_range(0, 1) == 1) p[(r+1)*C+c] = 1'b1;
                step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 1, p);
                if (last_lv) bg_v = bg_v | last_lsq;
                if ($urandom_range(0, 49) == 0) bg_v[$urandom_range(4 * C, N - 1)] ^= 1'b1;
            end
        end

        settle();
        settle();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
